// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Optional multi-beat grants are enabled with the FIFO_ARB_BURST_EN macro.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int CW        = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      grant,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_din,
  input  logic                 fifo_full,
  input  logic [CW-1:0]        fifo_cnt,
  output logic                 arb_state
);

  // Handshake: a word moves at a posedge where req[i] & ack[i]; ack is
  // combinational and only the owner can see it, and only when the FIFO has room.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  owner, rr, winner;
  logic           any_req, found, space, owner_req, xfer, last_beat, release_now;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  logic [BW-1:0]  beat;
  assign last_beat = (beat == BW'(BURST_LEN - 1));
`else
  localparam int UNUSED_BURST_LEN = BURST_LEN;
  assign last_beat = 1'b1;
`endif

  assign arb_state = state;

  // The in-flight write is counted; reads that free space are not anticipated.
  assign space = !fifo_full && (({1'b0, fifo_cnt} + SW'(fifo_wr)) < DEPTH_W);

  assign any_req     = |req;
  assign owner_req   = req[owner];
  assign xfer        = (state == GRANT) && owner_req && space;
  assign release_now = (state == GRANT) && (xfer ? last_beat : !owner_req);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[IW'((int'(rr) + i) % NREQ)]) begin
        winner = IW'((int'(rr) + i) % NREQ);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    case (state)
      IDLE:  if (any_req) state_nxt = GRANT;
      GRANT: begin
        ack[owner] = owner_req & space;
        if (release_now) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant    <= '0;
      owner    <= '0;
      rr       <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
    end else begin
      fifo_wr <= xfer;
      if (xfer) fifo_din <= req_data[int'(owner)*DW +: DW];
      if (state == IDLE && any_req) begin
        owner <= winner;
        grant <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
      end else if (release_now) begin
        grant <= '0;
        rr    <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        beat <= '0;
    else if (state == IDLE)          beat <= '0;
    else if (xfer && !release_now)   beat <= beat + 1'b1;
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the FIFO (`wr`/`din`) among `NREQ` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time and forwards accepted words to the FIFO one cycle later. It tracks FIFO occupancy so that no write is ever issued into a full FIFO. It sits between the producer blocks and the FIFO write side.

## Interface
- `NREQ`, 4 — number of requesters (2..8)
- `DW`, 8 — data width, equal to FIFO `din` width
- `DEPTH`, 8 — FIFO depth in words
- `CW`, 4 — width of `fifo_cnt`; must hold `DEPTH`
- `BURST_LEN`, 4 — maximum beats per grant (only used with `FIFO_ARB_BURST_EN`)

- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — asynchronous, active-low reset
- `req` in NREQ — requester `i` has a valid word
- `req_data` in NREQ*DW — word of requester `i` at bits `[i*DW +: DW]`; held stable while `req[i]` is high and not yet acked
- `ack` out NREQ — combinational ready; a transfer occurs at a posedge where `req[i] & ack[i]`
- `grant` out NREQ — registered one-hot owner; all zero when idle
- `fifo_wr` out 1 — registered write strobe to FIFO `wr`
- `fifo_din` out DW — registered write data to FIFO `din`
- `fifo_full` in 1 — FIFO `full` flag
- `fifo_cnt` in CW — FIFO occupancy

## Operation
- **Reset values** (`rst` low, asynchronous):
  - state IDLE
  - `grant` = 0, `ack` = 0, `fifo_wr` = 0, `fifo_din` = 0
  - round-robin pointer `rr` = 0
  - beat counter = 0
- **Space condition:** `space = !fifo_full && (fifo_cnt + fifo_wr) < DEPTH`.
  - The sum is computed at CW+1 bits.
  - `fifo_wr` counts the write in flight.
  - Reads that free space are not anticipated (conservative).
- **IDLE state:**
  - `ack` = 0.
  - If any `req` bit is high, the winner is the first set bit searching upward from `rr`, with wrap-around.
  - At the next edge, `grant` becomes the winner's one-hot value, state goes to GRANT, and the beat counter clears.
  - If no `req` bit is high, the block stays in IDLE.
- **GRANT state:**
  - `ack[owner] = req[owner] & space`; all other `ack` bits are 0.
  - On a transfer: `fifo_din <= req_data[owner]`, `fifo_wr <= 1`, beat counter increments.
  - Otherwise: `fifo_wr <= 0` and `fifo_din` holds its value.
- **Grant release** (return to IDLE with `grant` = 0 and `rr` = owner+1 mod NREQ). Release happens at the edge where either:
  - `req[owner]` is low, with no transfer that cycle; or
  - the transfer that completes beat `BURST_LEN` (burst mode), or every transfer (single-beat mode).
- **Stall on full:** while `req[owner]` is high and `space` is 0, the grant is held, the beat counter is frozen, and `ack` = 0. A requester never loses its grant because the FIFO is full.
- A requester must not change `req_data` or drop `req` before its ack. Dropping `req` releases the grant.
- Requesters that are not granted see `ack` = 0 and keep waiting; fairness comes from `rr`.

## Timing
- **First-beat latency:** `req` rises in cycle 0 with IDLE and space available → `grant` and `ack` in cycle 1 → transfer at the end of cycle 1 → `fifo_wr` high in cycle 2.
- **Throughput:** one beat per cycle within a grant. One idle arbitration cycle follows each release, so a full burst takes BURST_LEN+1 cycles.
- **Occupancy edge:** with `fifo_cnt` = DEPTH-1 and `fifo_wr` = 1, `space` = 0. This prevents a second write in the cycle before `fifo_cnt` updates.
- **Simultaneous requests:** only `rr` order decides the winner. After owner `k` is released, requester `k` has the lowest priority in the next arbitration.
- **Reset mid-burst:** outputs clear immediately, the in-flight `fifo_wr` is dropped, and the FSM returns to IDLE. The FIFO is reset by the same `rst`.

## Configuration
- **`FIFO_ARB_BURST_EN` defined:** the grant is held for up to `BURST_LEN` transfers (as described above).
- **`FIFO_ARB_BURST_EN` undefined:**
  - Every grant is exactly one transfer, and `BURST_LEN` is ignored.
  - The beat counter is not synthesized.
  - Throughput per requester is at most 1 word per 2 cycles.

## Test plan
- **Single requester:** `req[2]` = 1 with `req_data[2]` = 8'hA5, FIFO empty → `grant` = 4'b0100 in cycle 1, `ack[2]` = 1 in cycle 1, `fifo_wr` = 1 and `fifo_din` = 8'hA5 in cycle 2.
- **Round-robin:** all four `req` held high, burst off → grant order 0,1,2,3,0, with an idle cycle between grants; every `ack` is one cycle wide.
- **Burst:** `FIFO_ARB_BURST_EN`, `BURST_LEN` = 4, `req[1]` held high with incrementing data 1..6 → beats 1–4 written back-to-back, release, 1 idle cycle, then regrant; `fifo_wr` pattern 1111 0 11.
- **Full stall:** `fifo_cnt` = 7 with a write in flight → `ack` = 0 and `grant` held. Advance one read so `fifo_cnt` = 7 with no write in flight → `ack` reasserts and exactly 8 words sit in the FIFO; `full` never coincides with `fifo_wr` = 1.
- **Drop request:** owner deasserts `req` mid-burst after 2 beats → release at that edge, `rr` advances, the next requester is granted after one cycle.
- **Reset mid-burst:** `rst` goes low during a grant → `grant`, `ack`, `fifo_wr`, `fifo_din` = 0 within the same cycle (asynchronously). After release, `req[0]` = 1 is granted first (`rr` = 0).
